// File: rtl/alu_arbiter_if.sv
// Requester-facing channels of alu_arbiter: a request channel (op/operands) and a
// response channel (result), one valid/ready pair per requester on each.
interface alu_arbiter_if #(
  parameter int N   = 8,
  parameter int R   = 2,
  parameter int OPW = 4
);
  // A transfer happens on a rising clk edge where valid and ready are both high.
  // valid never waits on ready, and the payload holds while valid is high and not accepted.
  logic [R-1:0]     req_valid;
  logic [R-1:0]     req_ready;
  logic [R*OPW-1:0] req_op;
  logic [R*N-1:0]   req_a;
  logic [R*N-1:0]   req_b;
  logic [R-1:0]     resp_valid;
  logic [N-1:0]     resp_data;
  logic [R-1:0]     resp_ready;

  modport master (
    output req_valid, req_op, req_a, req_b, resp_ready,
    input  req_ready, resp_valid, resp_data
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, resp_ready,
    output req_ready, resp_valid, resp_data
  );
endinterface

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU among R requesters via an issue stage and a response stage.
// Define ALU_ARB_RR_EN for round-robin grant; otherwise the lowest valid index wins.
module alu_arbiter #(
  parameter int N   = 8,
  parameter int R   = 2,
  parameter int OPW = 4
) (
  input  logic           clk,
  input  logic           rst,
  alu_arbiter_if.slave   bus,
  output logic [OPW-1:0] alu_op,
  output logic [N-1:0]   alu_a,
  output logic [N-1:0]   alu_b,
  input  logic [N-1:0]   alu_out
);
  localparam int IW = (R > 1) ? $clog2(R) : 1;

  logic          iss_v;
  logic          res_v;
  logic [IW-1:0] iss_id;
  logic [IW-1:0] res_id;
  logic          res_adv;
  logic          iss_adv;
  logic          win_v;
  logic [IW-1:0] win;
  logic          accept;

`ifdef ALU_ARB_RR_EN
  logic [IW-1:0] rr_ptr;
`endif

  assign res_adv = !res_v || bus.resp_ready[res_id];
  assign iss_adv = !iss_v || res_adv;
  assign accept  = win_v && iss_adv && !rst;

  // Winner is the first valid requester scanning upward (modulo R) from the start index.
  always_comb begin
    logic [IW-1:0] idx;
    int            start;
    win   = '0;
    win_v = 1'b0;
    idx   = '0;
`ifdef ALU_ARB_RR_EN
    start = int'(rr_ptr);
`else
    start = 0;
`endif
    for (int k = 0; k < R; k++) begin
      idx = IW'((start + k) % R);
      if (!win_v && bus.req_valid[idx]) begin
        win_v = 1'b1;
        win   = idx;
      end
    end
  end

  always_comb begin
    bus.req_ready = '0;
    if (win_v && !rst) bus.req_ready[win] = iss_adv;
  end

  always_comb begin
    bus.resp_valid = '0;
    if (res_v) bus.resp_valid[res_id] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      iss_v         <= 1'b0;
      iss_id        <= '0;
      alu_op        <= '0;
      alu_a         <= '0;
      alu_b         <= '0;
      res_v         <= 1'b0;
      res_id        <= '0;
      bus.resp_data <= '0;
`ifdef ALU_ARB_RR_EN
      rr_ptr        <= '0;
`endif
    end else begin
      // The response stage takes the ALU result in the same cycle the issue stage may refill.
      if (res_adv) begin
        res_v <= iss_v;
        if (iss_v) begin
          bus.resp_data <= alu_out;
          res_id        <= iss_id;
        end
      end
      if (iss_adv) begin
        iss_v <= accept;
        if (accept) begin
          alu_op <= bus.req_op[int'(win)*OPW +: OPW];
          alu_a  <= bus.req_a[int'(win)*N +: N];
          alu_b  <= bus.req_b[int'(win)*N +: N];
          iss_id <= win;
`ifdef ALU_ARB_RR_EN
          rr_ptr <= (int'(win) == R - 1) ? '0 : win + 1'b1;
`endif
        end
      end
    end
  end
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter (R=2, N=8) with an in-bench ALU and a response scoreboard.
module tb_alu_arbiter;
  localparam int N   = 8;
  localparam int R   = 2;
  localparam int OPW = 4;
  localparam logic [3:0] OP_SUB = 4'b0001;

  typedef struct packed {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp;
  } vec_t;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  alu_arbiter_if #(.N(N), .R(R), .OPW(OPW)) bus ();
  logic [3:0] alu_op;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [7:0] alu_out;

  alu_arbiter #(.N(N), .R(R), .OPW(OPW)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .alu_op  (alu_op),
    .alu_a   (alu_a),
    .alu_b   (alu_b),
    .alu_out (alu_out)
  );

  function automatic logic [7:0] alu_calc(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      4'b0000: return a + b;
      4'b0001: return a - b;
      4'b0010: return a & b;
      4'b0011: return a | b;
      default: return a ^ b;
    endcase
  endfunction
  assign alu_out = alu_calc(alu_op, alu_a, alu_b);

  // scoreboard state
  int n_tests = 0;
  int n_fail  = 0;
  logic [9:0] exp_q[$];
  int         lat_q[$];
  int         gid_q[$];
  int         gcyc_q[$];
  vec_t       vq0[$];
  vec_t       vq1[$];
  bit         chk_lat;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // monitor: pop and compare on every response handshake
  logic [9:0] mon_e;
  int         mon_a;
  always @(negedge clk) begin
    if (!rst && ((bus.resp_valid & bus.resp_ready) != '0)) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL resp_unexpected: got valid=%b data=0x%0h, required no response",
                 bus.resp_valid, bus.resp_data);
      end else begin
        mon_e = exp_q.pop_front();
        mon_a = lat_q.pop_front();
        if ({bus.resp_valid, bus.resp_data} !== mon_e) begin
          n_fail++;
          $display("FAIL resp: got valid=%b data=0x%0h, required valid=%b data=0x%0h",
                   bus.resp_valid, bus.resp_data, mon_e[9:8], mon_e[7:0]);
        end
        if (mon_a >= 0) begin
          n_tests++;
          if (cyc - mon_a != 2) begin
            n_fail++;
            $display("FAIL latency: got %0d cycles, required 2", cyc - mon_a);
          end
        end
      end
    end
  end

  // driver tasks
  task automatic apply_heads();
    vec_t v;
    if (vq0.size() != 0) begin
      v = vq0[0];
      bus.req_valid[0] = 1'b1;
      bus.req_op[3:0]  = v.op;
      bus.req_a[7:0]   = v.a;
      bus.req_b[7:0]   = v.b;
    end else begin
      bus.req_valid[0] = 1'b0;
    end
    if (vq1.size() != 0) begin
      v = vq1[0];
      bus.req_valid[1] = 1'b1;
      bus.req_op[7:4]  = v.op;
      bus.req_a[15:8]  = v.a;
      bus.req_b[15:8]  = v.b;
    end else begin
      bus.req_valid[1] = 1'b0;
    end
  endtask

  task automatic note_accept(input int i, input logic [7:0] exp);
    logic [1:0] oh;
    oh = 2'b01 << i;
    exp_q.push_back({oh, exp});
    lat_q.push_back(chk_lat ? cyc : -1);
    gid_q.push_back(i);
    gcyc_q.push_back(cyc);
  endtask

  // Present queued vectors until every one is accepted; returns 1ns after the last accept edge.
  task automatic pump(input int budget);
    int   n;
    vec_t v;
    n = 0;
    apply_heads();
    while ((vq0.size() + vq1.size() != 0) && n < budget) begin
      @(negedge clk);
      if (bus.req_valid[0] && bus.req_ready[0]) begin
        v = vq0.pop_front();
        note_accept(0, v.exp);
      end
      if (bus.req_valid[1] && bus.req_ready[1]) begin
        v = vq1.pop_front();
        note_accept(1, v.exp);
      end
      @(posedge clk);
      #1;
      apply_heads();
      n++;
    end
    check("pump_pending", vq0.size() + vq1.size(), 0);
    vq0.delete();
    vq1.delete();
    apply_heads();
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 30) begin
      @(negedge clk);
      n++;
    end
    check("drain_pending", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    vq0.delete();
    vq1.delete();
    apply_heads();
    exp_q.delete();
    lat_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_req_ready"}, bus.req_ready, 0);
    check({tag, "_resp_valid"}, bus.resp_valid, 0);
    check({tag, "_resp_data"}, bus.resp_data, 0);
    check({tag, "_alu_op"}, alu_op, 0);
    check({tag, "_alu_a"}, alu_a, 0);
    check({tag, "_alu_b"}, alu_b, 0);
  endtask

  int exp_g[4];

  initial begin
    rst            = 1'b1;
    chk_lat        = 1'b1;
    bus.req_valid  = 2'b11;
    bus.req_op     = '0;
    bus.req_a      = '0;
    bus.req_b      = '0;
    bus.resp_ready = 2'b11;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_idle("reset");
    @(posedge clk);
    #1;
    bus.req_valid = 2'b00;
    rst           = 1'b0;

    // single SUB, latency 2
    vq0.push_back('{OP_SUB, 8'h03, 8'h01, 8'h02});
    pump(20);
    check("issue_op", alu_op, 4'b0001);
    check("issue_a", alu_a, 8'h03);
    check("issue_b", alu_b, 8'h01);
    drain();

    // back-to-back from req0, in-order results
    vq0.push_back('{OP_SUB, 8'h81, 8'h01, 8'h80});
    vq0.push_back('{OP_SUB, 8'h03, 8'h81, 8'h82});
    pump(20);
    drain();

    // both requesters contending
    do_reset();
    gid_q.delete();
    gcyc_q.delete();
    vq0.push_back('{OP_SUB, 8'h03, 8'h01, 8'h02});
    vq0.push_back('{OP_SUB, 8'h03, 8'h01, 8'h02});
    vq1.push_back('{OP_SUB, 8'hFC, 8'h01, 8'hFB});
    vq1.push_back('{OP_SUB, 8'hFC, 8'h01, 8'hFB});
    pump(20);
    drain();
`ifdef ALU_ARB_RR_EN
    exp_g = '{0, 1, 0, 1};
`else
    exp_g = '{0, 0, 1, 1};
`endif
    check("grant_count", gid_q.size(), 4);
    for (int k = 0; k < 4 && k < gid_q.size(); k++) begin
      check($sformatf("grant_%0d", k), gid_q[k], exp_g[k]);
      if (k > 0) check($sformatf("grant_gap_%0d", k), gcyc_q[k] - gcyc_q[k-1], 1);
    end

    // backpressure on req1's result
    chk_lat        = 1'b0;
    bus.resp_ready = 2'b01;
    vq1.push_back('{OP_SUB, 8'hFC, 8'h01, 8'hFB});
    pump(20);
    vq0.push_back('{OP_SUB, 8'h03, 8'h01, 8'h02});
    pump(20);
    vq0.push_back('{OP_SUB, 8'h81, 8'h01, 8'h80});
    apply_heads();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("bp_valid_%0d", k), bus.resp_valid, 2'b10);
      check($sformatf("bp_data_%0d", k), bus.resp_data, 8'hFB);
      check($sformatf("bp_ready_%0d", k), bus.req_ready, 2'b00);
    end
    @(posedge clk);
    #1;
    bus.resp_ready = 2'b11;
    pump(20);
    drain();
    chk_lat = 1'b1;

    // reset one cycle after accept discards the request
    vq0.push_back('{OP_SUB, 8'h05, 8'h01, 8'h04});
    pump(20);
    rst = 1'b1;
    exp_q.delete();
    lat_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_idle("post_rst");
    repeat (6) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1, "watchdog expired");
  end
endmodule
